// File: rtl/seg7_pkg.sv
// seg7_pkg: segment-pattern constants and FSM state type shared by the
// seven-segment capture encoder and its pattern encoder.
package seg7_pkg;
    typedef enum logic [0:0] {COLLECT = 1'b0, HOLD = 1'b1} state_t;
    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    // Indexed by the hex value the pattern displays.
    localparam logic [15:0][6:0] SEG_TABLE = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                              SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
endpackage

// File: rtl/seg7_pattern_encoder.sv
// seg7_pattern_encoder: maps an active-low 7-segment pattern back to its hex nibble.
module seg7_pattern_encoder
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic       valid_o,
    output logic [3:0] nibble_o
);
    always_comb begin
        valid_o = 1'b0;
        nibble_o = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_TABLE[i]) begin
                valid_o = 1'b1;
                nibble_o = 4'(i);
            end
        end
    end
endmodule

// File: rtl/seg7_capture_encoder.sv
// seg7_capture_encoder: collects NUM_DIGITS segment patterns into a hex word,
// flags unrecognised patterns and holds the word until the consumer takes it.
module seg7_capture_encoder
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic                    seg_valid,
    output logic                    seg_ready,
    output logic [4*NUM_DIGITS-1:0] word_out,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic [NUM_DIGITS-1:0]   err_mask,
    output logic                    err_any,
    output logic [7:0]              bad_count
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int WW = 4 * NUM_DIGITS;
    logic                  ok;
    logic [3:0]            nib;
    logic                  accept;
    logic                  last;
    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [WW-1:0]         word_q, word_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_d;
    logic [7:0]            bad_q, bad_d;

    seg7_pattern_encoder u_enc (
        .seg_i   (seg_in),
        .valid_o (ok),
        .nibble_o(nib)
    );

    assign seg_ready  = state_q == COLLECT;
    assign word_valid = state_q == HOLD;
    assign word_out   = word_q;
    assign err_mask   = mask_q;
    assign err_any    = |mask_q;
    assign bad_count  = bad_q;
    assign accept     = seg_valid && seg_ready;
    assign last       = idx_q == IW'(NUM_DIGITS - 1);

    // First-accepted digit ends up in the top nibble after NUM_DIGITS shifts.
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        word_d = word_q;
        mask_d = mask_q;
        bad_d = bad_q;
        if (accept) begin
            word_d = (word_q << 4) | WW'(nib);
            mask_d = (mask_q << 1) | NUM_DIGITS'(!ok);
            bad_d = (!ok && bad_q != 8'hFF) ? bad_q + 8'd1 : bad_q;
            idx_d = last ? '0 : idx_q + 1'b1;
            state_d = last ? HOLD : COLLECT;
        end else if (word_valid && word_ready) begin
            state_d = COLLECT;
            idx_d = '0;
            mask_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT;
            idx_q <= '0;
            word_q <= '0;
            mask_q <= '0;
            bad_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            word_q <= word_d;
            mask_q <= mask_d;
            bad_q <= bad_d;
        end
    end
endmodule

// File: tb/tb_seg7_capture_encoder.sv
// tb_seg7_capture_encoder: directed checks of capture, hold, error flagging,
// reset discard and counter saturation.
module tb_seg7_capture_encoder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  seg_in = 7'h7F;
    logic        seg_valid = 1'b0;
    logic        seg_ready;
    logic [15:0] word_out;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic [3:0]  err_mask;
    logic        err_any;
    logic [7:0]  bad_count;
    int          checks = 0;
    int          errors = 0;
    int          wv_cycles = 0;
    logic [6:0]  pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_capture_encoder #(.NUM_DIGITS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .seg_in    (seg_in),
        .seg_valid (seg_valid),
        .seg_ready (seg_ready),
        .word_out  (word_out),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .err_mask  (err_mask),
        .err_any   (err_any),
        .bad_count (bad_count)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (word_valid) wv_cycles++;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] p);
        seg_in = p;
        seg_valid = 1'b1;
        tick();
        seg_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        checks++; if (seg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", seg_ready); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL rst_wv: got %b expected 0", word_valid); end
        checks++; if (word_out !== 16'h0000) begin errors++; $display("FAIL rst_word: got %h expected 0000", word_out); end
        checks++; if (err_mask !== 4'b0000 || err_any !== 1'b0) begin errors++; $display("FAIL rst_err: got %b/%b expected 0000/0", err_mask, err_any); end
        checks++; if (bad_count !== 8'd0) begin errors++; $display("FAIL rst_bad: got %0d expected 0", bad_count); end
    endtask

    task automatic test_basic();
        int c0 = wv_cycles;
        word_ready = 1'b1;
        send(7'h79); send(7'h24); send(7'h30);
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL basic_early_wv: got %b expected 0", word_valid); end
        send(7'h19);
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL basic_wv: got %b expected 1", word_valid); end
        checks++; if (word_out !== 16'h1234) begin errors++; $display("FAIL basic_word: got %h expected 1234", word_out); end
        checks++; if (err_any !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", err_any); end
        tick();
        checks++; if (word_valid !== 1'b0 || seg_ready !== 1'b1) begin errors++; $display("FAIL basic_release: got wv=%b rdy=%b expected wv=0 rdy=1", word_valid, seg_ready); end
        checks++; if (wv_cycles - c0 !== 1) begin errors++; $display("FAIL basic_pulse: got %0d cycles expected 1", wv_cycles - c0); end
        word_ready = 1'b0;
    endtask

    task automatic test_hold();
        send(7'h08); send(7'h03); send(7'h46); send(7'h0E);
        seg_in = 7'h40;
        seg_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (word_valid !== 1'b1 || seg_ready !== 1'b0) begin errors++; $display("FAIL hold_hs[%0d]: got wv=%b rdy=%b expected wv=1 rdy=0", i, word_valid, seg_ready); end
            checks++; if (word_out !== 16'hABCF) begin errors++; $display("FAIL hold_word[%0d]: got %h expected abcf", i, word_out); end
            tick();
        end
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        seg_valid = 1'b0;
        checks++; if (word_valid !== 1'b0 || seg_ready !== 1'b1) begin errors++; $display("FAIL hold_release: got wv=%b rdy=%b expected wv=0 rdy=1", word_valid, seg_ready); end
        checks++; if (word_out !== 16'hABCF) begin errors++; $display("FAIL hold_keep: got %h expected abcf", word_out); end
        tick();
        checks++; if (word_out !== 16'hABCF) begin errors++; $display("FAIL hold_no_overlap: got %h expected abcf", word_out); end
    endtask

    task automatic test_errors();
        send(7'h40); send(7'h7F); send(7'h55); send(7'h00);
        checks++; if (word_out !== 16'h0008) begin errors++; $display("FAIL err_word: got %h expected 0008", word_out); end
        checks++; if (err_mask !== 4'b0110) begin errors++; $display("FAIL err_mask: got %b expected 0110", err_mask); end
        checks++; if (err_any !== 1'b1) begin errors++; $display("FAIL err_any: got %b expected 1", err_any); end
        checks++; if (bad_count !== 8'd2) begin errors++; $display("FAIL err_bad: got %0d expected 2", bad_count); end
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        checks++; if (err_mask !== 4'b0000 || err_any !== 1'b0) begin errors++; $display("FAIL err_clear: got %b/%b expected 0000/0", err_mask, err_any); end
    endtask

    task automatic test_reset_mid();
        int c0;
        send(7'h12); send(7'h02);
        seg_in = 7'h78;
        seg_valid = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        seg_valid = 1'b0;
        checks++; if (word_out !== 16'h0000 || bad_count !== 8'd0) begin errors++; $display("FAIL mid_rst: got %h/%0d expected 0000/0", word_out, bad_count); end
        c0 = wv_cycles;
        word_ready = 1'b1;
        send(7'h12); send(7'h02); send(7'h78); send(7'h10);
        checks++; if (word_out !== 16'h5679 || word_valid !== 1'b1) begin errors++; $display("FAIL mid_word: got %h wv=%b expected 5679 wv=1", word_out, word_valid); end
        tick();
        word_ready = 1'b0;
        checks++; if (wv_cycles - c0 !== 1) begin errors++; $display("FAIL mid_pulses: got %0d expected 1", wv_cycles - c0); end
        send(7'h40); send(7'h40); send(7'h40); send(7'h40);
        reset = 1'b1;
        word_ready = 1'b1;
        tick();
        reset = 1'b0;
        word_ready = 1'b0;
        checks++; if (word_valid !== 1'b0 || seg_ready !== 1'b1 || word_out !== 16'h0000) begin errors++; $display("FAIL hold_rst: got wv=%b rdy=%b word=%h expected 0 1 0000", word_valid, seg_ready, word_out); end
    endtask

    task automatic test_roundtrip();
        for (int d = 0; d < 4; d++) begin
            logic [15:0] exp = 16'h0;
            for (int k = 0; k < 4; k++) begin
                int gap = $urandom_range(0, 2);
                repeat (gap) begin
                    seg_in = 7'($urandom);
                    tick();
                end
                send(pat[4*d+k]);
                exp = (exp << 4) | 16'(4*d+k);
            end
            checks++; if (word_out !== exp || err_any !== 1'b0 || word_valid !== 1'b1) begin errors++; $display("FAIL rt_word[%0d]: got %h err=%b wv=%b expected %h err=0 wv=1", d, word_out, err_any, word_valid, exp); end
            word_ready = 1'b1;
            tick();
            word_ready = 1'b0;
        end
    endtask

    task automatic test_saturate();
        word_ready = 1'b1;
        for (int w = 0; w < 75; w++) begin
            for (int k = 0; k < 4; k++) send(k[0] ? 7'h55 : 7'h7F);
            checks++; if (err_mask !== 4'b1111) begin errors++; $display("FAIL sat_mask[%0d]: got %b expected 1111", w, err_mask); end
            tick();
            if (w == 62) begin
                checks++; if (bad_count !== 8'd252) begin errors++; $display("FAIL sat_mid: got %0d expected 252", bad_count); end
            end
        end
        word_ready = 1'b0;
        checks++; if (bad_count !== 8'd255) begin errors++; $display("FAIL sat_final: got %0d expected 255", bad_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_errors();
        test_reset_mid();
        test_roundtrip();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
